// File: rtl/sng_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : sng_lfsr
// Purpose  : Stochastic number generator. Turns a WIDTH-bit value into one
//            full-period unipolar bitstream by comparison against an LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module sng_lfsr #(
  parameter int WIDTH = 6,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_SEED_RAW = SEED[WIDTH-1:0];
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [WIDTH-1:0] c_SEED = (c_SEED_RAW == '0) ?
                                        {{(WIDTH-1){1'b0}}, 1'b1} : c_SEED_RAW;
  localparam logic [WIDTH-1:0] c_LAST = WIDTH'((1 << WIDTH) - 2);

  state_t           r_state;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_lfsr;
  logic             w_fb;
  logic             w_run;
  logic [WIDTH-1:0] w_lfsr_nxt;

  generate
    if (WIDTH == 4) begin : g_w4
      assign w_fb = r_lfsr[3] ^ r_lfsr[2];
    end else if (WIDTH == 5) begin : g_w5
      assign w_fb = r_lfsr[4] ^ r_lfsr[2];
    end else if (WIDTH == 6) begin : g_w6
      assign w_fb = r_lfsr[5] ^ r_lfsr[4];
    end else if (WIDTH == 7) begin : g_w7
      assign w_fb = r_lfsr[6] ^ r_lfsr[5];
    end else begin : g_w8
      assign w_fb = r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-3] ^ r_lfsr[WIDTH-4] ^ r_lfsr[WIDTH-5];
    end
  endgenerate

  assign w_lfsr_nxt = {r_lfsr[WIDTH-2:0], w_fb};
  assign w_run      = (r_state == S_RUN);

  assign out_valid = w_run;
  assign out_last  = w_run & (r_cnt == c_LAST);
  assign out       = w_run & (r_lfsr <= r_val);
  assign in_ready  = ~w_run | (out_ready & out_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= c_SEED;
      r_cnt   <= '0;
      r_val   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_val   <= in_data;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            r_lfsr <= w_lfsr_nxt;
            if (r_cnt == c_LAST) begin
              // Final bit consumed: chain straight into the next value if offered.
              if (in_valid) begin
                r_val <= in_data;
                r_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sng_lfsr.sv
`default_nettype none
// Testbench for sng_lfsr: WIDTH=6/SEED=1 and WIDTH=4/SEED=0 instances checked
// against a precomputed LFSR orbit and per-stream ones counts.
module tb_sng_lfsr;
  localparam int P6 = 63;
  localparam int P4 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst6, iv6, or6, ir6, o6, ov6, ol6;
  logic [5:0] d6;
  logic       rst4, iv4, or4, ir4, o4, ov4, ol4;
  logic [3:0] d4;

  sng_lfsr #(.WIDTH(6), .SEED(1)) dut6 (
    .clk(clk), .rst(rst6), .in_valid(iv6), .in_ready(ir6), .in_data(d6),
    .out(o6), .out_valid(ov6), .out_ready(or6), .out_last(ol6));

  sng_lfsr #(.WIDTH(4), .SEED(0)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(d4),
    .out(o4), .out_valid(ov4), .out_ready(or4), .out_last(ol4));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // LFSR orbit from the tap lists: parity of tapped bits shifted in at the LSB.
  function automatic int lfsr_next(input int s, input int w);
    int mask;
    case (w)
      4: mask = 'b1100;
      5: mask = 'b10100;
      6: mask = 'b110000;
      7: mask = 'b1100000;
      default: mask = 'b10111000;
    endcase
    return ((s << 1) | ($countones(s & mask) & 1)) & ((1 << w) - 1);
  endfunction

  int seq6[P6];
  int seq4[P4];

  // Reference model state for the WIDTH=6 instance
  bit busy6;
  int pos6, idx6, val6, ones6, streams6, ov_cycles6;
  bit cap6[$];
  bit last_seq6[$];

  task automatic start6(input int d);
    busy6 = 1; val6 = d; idx6 = 0; ones6 = 0; cap6.delete();
  endtask

  task automatic cyc6(input bit r, input bit iv, input int d, input bit ordy);
    rst6 = r; iv6 = iv; d6 = 6'(d); or6 = ordy;
    #1;
    chk("w6_out_valid", int'(ov6), int'(busy6));
    chk("w6_out", int'(o6), (busy6 && (seq6[pos6] <= val6)) ? 1 : 0);
    chk("w6_out_last", int'(ol6), (busy6 && idx6 == P6 - 1) ? 1 : 0);
    chk("w6_in_ready", int'(ir6), (!busy6 || (ordy && idx6 == P6 - 1)) ? 1 : 0);
    ov_cycles6 += int'(ov6);
    if (r) begin
      busy6 = 0; pos6 = 0; idx6 = 0; val6 = 0;
    end else if (busy6) begin
      if (ordy) begin
        ones6 += int'(o6);
        cap6.push_back(o6);
        pos6 = (pos6 + 1) % P6;
        if (idx6 == P6 - 1) begin
          chk("w6_ones", ones6, val6);
          last_seq6 = cap6;
          streams6++;
          if (iv) start6(d);
          else busy6 = 0;
        end else begin
          idx6++;
        end
      end
    end else if (iv) begin
      start6(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream6(input int v, input bit stall);
    int guard;
    cyc6(0, 1, v, 1);
    guard = 0;
    while (busy6 && guard < 1000) begin
      cyc6(0, 0, 0, stall ? 1'($urandom % 2) : 1'b1);
      guard++;
    end
    if (busy6) chk("w6_timeout", 1, 0);
  endtask

  // Reference model state for the WIDTH=4 instance
  bit busy4;
  int pos4, idx4, val4, ones4;

  task automatic cyc4(input bit iv, input int d);
    iv4 = iv; d4 = 4'(d); or4 = 1'b1;
    #1;
    chk("w4_out_valid", int'(ov4), int'(busy4));
    chk("w4_out", int'(o4), (busy4 && (seq4[pos4] <= val4)) ? 1 : 0);
    chk("w4_out_last", int'(ol4), (busy4 && idx4 == P4 - 1) ? 1 : 0);
    chk("w4_lfsr", int'(dut4.r_lfsr), seq4[pos4]);
    chk("w4_lfsr_nonzero", (dut4.r_lfsr != 0) ? 1 : 0, 1);
    if (busy4) begin
      ones4 += int'(o4);
      pos4 = (pos4 + 1) % P4;
      if (idx4 == P4 - 1) begin
        chk("w4_ones", ones4, val4);
        busy4 = 0;
      end else begin
        idx4++;
      end
    end else if (iv) begin
      busy4 = 1; val4 = d; idx4 = 0; ones4 = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s, base, c0, guard, diffs;
    bit seq_a[$];

    s = 1;
    for (int i = 0; i < P6; i++) begin seq6[i] = s; s = lfsr_next(s, 6); end
    s = 1;
    for (int i = 0; i < P4; i++) begin seq4[i] = s; s = lfsr_next(s, 4); end

    rst6 = 1; iv6 = 0; d6 = '0; or6 = 1;
    rst4 = 1; iv4 = 0; d4 = '0; or4 = 1;
    repeat (2) @(posedge clk);
    #1;
    rst6 = 0; rst4 = 0;
    busy6 = 0; pos6 = 0; idx6 = 0; streams6 = 0; ov_cycles6 = 0;
    busy4 = 0; pos4 = 0; idx4 = 0;

    // WIDTH=4, SEED=0: orbit starts at 1, v=7 gives 7 ones in 15 bits
    cyc4(1, 7);
    guard = 0;
    while (busy4 && guard < 100) begin cyc4(0, 0); guard++; end
    if (busy4) chk("w4_timeout", 1, 0);
    cyc4(0, 0);

    // WIDTH=6 reset values
    chk("w6_rst_lfsr", int'(dut6.r_lfsr), 1);
    cyc6(0, 0, 0, 1);

    // Zero and full scale, then exact counts
    stream6(0, 0);
    cyc6(0, 0, 0, 1);
    stream6(63, 0);
    stream6(32, 0);
    stream6(1, 0);
    stream6(62, 0);

    // Back-to-back: 10 then 50, no idle cycle between streams
    cyc6(0, 1, 10, 1);
    base = streams6; c0 = ov_cycles6; guard = 0;
    while (streams6 < base + 2 && guard < 400) begin
      cyc6(0, streams6 == base, 50, 1);
      guard++;
    end
    chk("w6_b2b_valid_cycles", ov_cycles6 - c0, 126);

    // Stalled stream
    stream6(20, 1);

    // Reset mid-stream, then reproducibility of the post-reset sequence
    cyc6(1, 0, 0, 1);
    stream6(40, 0);
    seq_a = last_seq6;
    cyc6(0, 1, 40, 1);
    for (int i = 0; i < 29; i++) cyc6(0, 0, 0, 1);
    chk("w6_at_bit30_valid", int'(ov6), 1);
    cyc6(1, 0, 0, 1);
    chk("w6_post_rst_lfsr", int'(dut6.r_lfsr), 1);
    cyc6(0, 0, 0, 1);
    stream6(40, 0);
    diffs = 0;
    for (int i = 0; i < P6; i++)
      if (i >= seq_a.size() || i >= last_seq6.size() || seq_a[i] != last_seq6[i]) diffs++;
    chk("w6_reset_repro_diffs", diffs, 0);

    // Random values with random stalls
    for (int k = 0; k < 4; k++) stream6(int'($urandom_range(0, 63)), 1);
    cyc6(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sng_lfsr.md
# sng_lfsr

Stochastic number generator feeding the unipolar bitstream stages (ReLU, multipliers, adders) of the stochastic datapath. It accepts a WIDTH-bit unsigned binary value through a valid/ready handshake. It then emits exactly one full-period bitstream of 2^WIDTH-1 bits whose count of ones equals the value exactly. Bits are produced by comparing against a maximal-length LFSR, and downstream can stall the stream bit by bit.

## Interface
- WIDTH, 6: binary input width and LFSR length; legal 4..8.
- SEED, 1: LFSR reset value, WIDTH bits; SEED=0 is illegal and is replaced by 1.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data holds a value to encode.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  unsigned value v, 0..2^WIDTH-1.
- out  output  1  stochastic bit; meaningful only while out_valid=1.
- out_valid  output  1  out carries a stream bit.
- out_ready  input  1  downstream consumes the bit this cycle.
- out_last  output  1  current bit is the final bit (2^WIDTH-1th) of the stream.

## Operation
- State: two states, IDLE and RUN. There is also a value register val[WIDTH-1:0], a bit counter cnt[WIDTH-1:0], and an LFSR lfsr[WIDTH-1:0].
- LFSR: Fibonacci, shifts left, next = {lfsr[WIDTH-2:0], fb}. fb is the XOR of these tap bits (1-indexed, bit n = lfsr[n-1]):
  - W4: 4,3
  - W5: 5,3
  - W6: 6,5
  - W7: 7,6
  - W8: 8,6,5,4
- The LFSR never reaches 0, so over any 2^WIDTH-1 consecutive advances it visits each of 1..2^WIDTH-1 exactly once.
- Bit generation: out = (lfsr <= val) & (state==RUN). The number of ones per stream is exactly v. v=0 gives all zeros; v=2^WIDTH-1 gives all ones.
- Advance: lfsr and cnt change only on a bit handshake (out_valid & out_ready). The LFSR is free-running across streams and is not reseeded per stream.
- IDLE: in_ready=1, out_valid=0. If in_valid is high: latch val<=in_data, cnt<=0, go to RUN.
- RUN: out_valid=1, out_last=(cnt==2^WIDTH-2).
  - Handshake with out_last=0: cnt<=cnt+1, lfsr advances.
  - Handshake with out_last=1: lfsr advances. If in_valid is also high, latch the new value, set cnt<=0, and stay in RUN (back-to-back, no bubble). Otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is combinational from state and out_ready.
- in_data is ignored whenever in_ready=0. A value offered mid-stream waits; it is not dropped or overwritten.
- Reset: state<=IDLE, lfsr<=SEED (1 if SEED=0), cnt<=0, val<=0. Reset wins over any simultaneous handshake. A stream cut by reset mid-way is abandoned; no out_last is emitted for it.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out=0
  - out_last=0
- Latency: value accepted at edge t; first bit valid in cycle t+1. Stream occupies ≥2^WIDTH-1 cycles, exactly 2^WIDTH-1 with out_ready held high.
- Throughput: one bit per cycle with no stalls. Back-to-back streams have zero idle cycles.
- While out_ready=0 in RUN, out, out_valid, out_last, lfsr, cnt and val all hold stable.
- out, out_valid and out_last depend only on registered state; there is no combinational path from out_ready or in_valid to them.
- The only combinational path from inputs to outputs is out_ready to in_ready.

## Test plan
- Full-scale and zero, WIDTH=6, out_ready=1:
  - v=0: 63 bits, all 0; out_last on bit 63; in_ready=1 in cycle after.
  - v=63: 63 ones.
- Exact count: v=32, then v=1 and v=62 (WIDTH=6). The ones counted over each 63-bit stream must be 32, 1 and 62. The first bit equals (SEED<=v).
- Back-to-back: in_valid held with v=10 then v=50. Second value is accepted on the out_last handshake of the first. Result is 126 consecutive out_valid cycles with ones counts 10 and 50.
- Stall: v=20 with out_ready toggled pseudo-randomly at 50%.
  - Outputs must hold during stalls.
  - The accepted bit sequence must be identical to the unstalled run.
  - Exactly 20 ones.
- Reset mid-stream: rst asserted at bit 30 of v=40.
  - Next cycle: out_valid=0, in_ready=1, lfsr=SEED.
  - A new v=40 stream reproduces the same 63-bit sequence as a post-reset run.
- SEED=0 with WIDTH=4: lfsr starts at 1. v=7 produces a 15-bit stream with 7 ones; the LFSR never reads 0.
